// File: rtl/hazard_pkg.sv
// Shared types and constants for the OTTER pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hz_state_t;

  typedef logic [4:0] reg_addr_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // A producer matters only if it writes a register other than x0.
  function automatic logic raw_hit(reg_addr_t rd, logic we, reg_addr_t rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Datapath <-> hazard controller bundle: stage register fields in, stall/flush/forward out.
interface hazard_if;
  import hazard_pkg::*;

  reg_addr_t   rs1_addr_D, rs2_addr_D;
  reg_addr_t   rs1_addr_E, rs2_addr_E;
  reg_addr_t   rd_E, rd_M, rd_W;
  logic        regWrite_E, regWrite_M, regWrite_W;
  logic        memRead2_E;
  logic        pc_src_E;
  logic        mem_req_M;
  logic        mem_ready;

  logic        stall_F, stall_D, stall_E, stall_M;
  logic        flush_D, flush_E, flush_W;
  logic [1:0]  fwdA_E, fwdB_E;
  logic        mem_err;
  logic [31:0] stall_cycles;

  modport master (
    output rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
           rd_E, rd_M, rd_W, regWrite_E, regWrite_M, regWrite_W,
           memRead2_E, pc_src_E, mem_req_M, mem_ready,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwdA_E, fwdB_E, mem_err, stall_cycles
  );

  modport slave (
    input  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E,
           rd_E, rd_M, rd_W, regWrite_E, regWrite_M, regWrite_W,
           memRead2_E, pc_src_E, mem_req_M, mem_ready,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwdA_E, fwdB_E, mem_err, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Two-level priority comparator: producer A (nearer stage) beats producer B.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  reg_addr_t  rs,
  input  reg_addr_t  rd_a,
  input  logic       we_a,
  input  reg_addr_t  rd_b,
  input  logic       we_b,
  output logic [1:0] sel
);
  assign sel = raw_hit(rd_a, we_a, rs) ? FWD_M :
               raw_hit(rd_b, we_b, rs) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// OTTER hazard/stall controller with memory-wait FSM and timeout.
// HAZARD_FORWARDING_EN: enable E-stage forwarding; otherwise stall on any D-stage RAW vs E/M.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input logic      CLK,
  input logic      RST,
  hazard_if.slave  hif
);
  localparam int WCW_MIN = $clog2(MEM_TIMEOUT) + 1;
  localparam int WCW     = (WCW_MIN > 7) ? WCW_MIN : 7;

  hz_state_t        state;
  logic [WCW-1:0]   wait_cnt;
  logic             mem_err_q;
  logic [31:0]      stall_cnt;

  logic mem_stall, raw_stall;
  logic s_f, s_d, s_e, s_m, f_d, f_e, f_w;

  // One comparator per operand; what it compares depends on the build.
  reg_addr_t [1:0]       cmp_rs;
  logic      [1:0][1:0]  cmp_sel;
  reg_addr_t             rd_a, rd_b;
  logic                  we_a, we_b;

  for (genvar g = 0; g < 2; g++) begin : g_cmp
    hazard_fwd_sel u_sel (
      .rs   (cmp_rs[g]),
      .rd_a (rd_a),
      .we_a (we_a),
      .rd_b (rd_b),
      .we_b (we_b),
      .sel  (cmp_sel[g])
    );
  end

`ifdef HAZARD_FORWARDING_EN
  assign cmp_rs     = {hif.rs2_addr_E, hif.rs1_addr_E};
  assign rd_a       = hif.rd_M;
  assign we_a       = hif.regWrite_M;
  assign rd_b       = hif.rd_W;
  assign we_b       = hif.regWrite_W;
  assign hif.fwdA_E = cmp_sel[0];
  assign hif.fwdB_E = cmp_sel[1];
  assign raw_stall  = hif.memRead2_E &&
                      (raw_hit(hif.rd_E, hif.regWrite_E, hif.rs1_addr_D) ||
                       raw_hit(hif.rd_E, hif.regWrite_E, hif.rs2_addr_D));
`else
  // Without bypass paths, D-stage sources are checked against E and M; W is write-first.
  assign cmp_rs     = {hif.rs2_addr_D, hif.rs1_addr_D};
  assign rd_a       = hif.rd_E;
  assign we_a       = hif.regWrite_E;
  assign rd_b       = hif.rd_M;
  assign we_b       = hif.regWrite_M;
  assign hif.fwdA_E = FWD_RF;
  assign hif.fwdB_E = FWD_RF;
  assign raw_stall  = |cmp_sel;
  logic unused_fwd;
  assign unused_fwd = ^{hif.rs1_addr_E, hif.rs2_addr_E, hif.rd_W,
                        hif.regWrite_W, hif.memRead2_E};
`endif

  assign mem_stall = ((state == RUN) && hif.mem_req_M && !hif.mem_ready) ||
                     ((state == MEM_WAIT) && !hif.mem_ready) ||
                     (state == ERR);

  always_comb begin
    {s_f, s_d, s_e, s_m, f_d, f_e, f_w} = 7'b0;
    if (RST) begin
      {f_d, f_e, f_w} = 3'b111;
    end else if (mem_stall) begin
      {s_f, s_d, s_e, s_m, f_w} = 5'b11111;
    end else if (hif.pc_src_E) begin
      {f_d, f_e} = 2'b11;
    end else if (raw_stall) begin
      {s_f, s_d, f_e} = 3'b111;
    end
  end

  assign {hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M} = {s_f, s_d, s_e, s_m};
  assign {hif.flush_D, hif.flush_E, hif.flush_W}              = {f_d, f_e, f_w};
  assign hif.mem_err      = mem_err_q;
  assign hif.stall_cycles = stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state)
        RUN: if (hif.mem_req_M && !hif.mem_ready) begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
        MEM_WAIT: begin
          if (hif.mem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
            state     <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR:     ;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             stall_cnt <= '0;
    else if (s_f && (stall_cnt != '1))   stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand-written sequences, random vs model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int TMO = 4;
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_RST  = 7'b0000111;

  logic CLK = 1'b0;
  logic RST;
  hazard_if hif();

  hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (.CLK(CLK), .RST(RST), .hif(hif.slave));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       weE, weM, weW, ldE, pc, req, rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] c_on;
    logic [1:0] fa, fb;
    logic [6:0] c_off;
  } tv_t;

  int total = 0;
  int bad   = 0;

  // Model: count of consecutive unacknowledged memory-stall cycles, plus sticky error.
  int          m_pend;
  logic        m_err;
  longint      m_sc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] dut_code();
    return {hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M,
            hif.flush_D, hif.flush_E, hif.flush_W};
  endfunction

  task automatic apply(in_t v);
    hif.rs1_addr_D = v.rs1D; hif.rs2_addr_D = v.rs2D;
    hif.rs1_addr_E = v.rs1E; hif.rs2_addr_E = v.rs2E;
    hif.rd_E = v.rdE; hif.rd_M = v.rdM; hif.rd_W = v.rdW;
    hif.regWrite_E = v.weE; hif.regWrite_M = v.weM; hif.regWrite_W = v.weW;
    hif.memRead2_E = v.ldE; hif.pc_src_E = v.pc;
    hif.mem_req_M = v.req; hif.mem_ready = v.rdy;
  endtask

  function automatic logic hit(logic [4:0] rd, logic we, logic [4:0] rs);
    return we && rd != 0 && rd == rs;
  endfunction

  function automatic logic [6:0] m_code(in_t v, logic rst);
    logic haz;
    if (rst) return C_RST;
    if (m_err || (!v.rdy && (m_pend > 0 || v.req))) return C_MEM;
    if (v.pc) return C_BR;
`ifdef HAZARD_FORWARDING_EN
    haz = v.ldE && (hit(v.rdE, v.weE, v.rs1D) || hit(v.rdE, v.weE, v.rs2D));
`else
    haz = hit(v.rdE, v.weE, v.rs1D) || hit(v.rdE, v.weE, v.rs2D) ||
          hit(v.rdM, v.weM, v.rs1D) || hit(v.rdM, v.weM, v.rs2D);
`endif
    return haz ? C_LU : C_NONE;
  endfunction

  function automatic logic [1:0] m_fwd(in_t v, logic [4:0] rs);
`ifdef HAZARD_FORWARDING_EN
    if (hit(v.rdM, v.weM, rs)) return 2'b10;
    if (hit(v.rdW, v.weW, rs)) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic do_reset();
    in_t z;
    z = '{default: 0};
    RST = 1'b1;
    apply(z);
    m_pend = 0; m_err = 1'b0; m_sc = 0;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  tv_t tv[13];

  initial begin
    in_t z, v;
    logic [6:0] ec;
    logic r;

    z = '{default: 0};
    //           rs1D  rs2D  rs1E  rs2E  rdE   rdM   rdW   weE  weM  weW  ldE  pc   req  rdy
    tv[0]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b00, C_NONE};
    tv[1]  = '{'{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0}, C_LU,   2'b00, 2'b00, C_LU};
    tv[2]  = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b00, C_NONE};
    tv[3]  = '{'{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0}, C_BR,   2'b00, 2'b00, C_BR};
    tv[4]  = '{'{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd7, 5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b10, C_NONE};
    tv[5]  = '{'{5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b01, C_NONE};
    tv[6]  = '{'{5'd3, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b10, 2'b00, C_LU};
    tv[7]  = '{'{5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b00, C_LU};
    tv[8]  = '{'{5'd4, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b01, 2'b00, C_NONE};
    tv[9]  = '{'{5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0}, C_NONE, 2'b00, 2'b00, C_NONE};
    tv[10] = '{'{5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd2, 5'd2, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0}, C_NONE, 2'b01, 2'b01, C_NONE};
    tv[11] = '{'{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1}, C_NONE, 2'b00, 2'b00, C_NONE};
    tv[12] = '{'{5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0}, C_LU,   2'b00, 2'b00, C_LU};

    // Reset state, including async assertion mid-cycle
    RST = 1'b1;
    apply(z);
    #2;
    chk("rst_code", 32'(dut_code()), 32'(C_RST));
    chk("rst_err", 32'(hif.mem_err), 32'd0);
    chk("rst_sc", hif.stall_cycles, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // Vector table, state RUN
    foreach (tv[i]) begin
      apply(tv[i].in);
      @(negedge CLK);
`ifdef HAZARD_FORWARDING_EN
      chk($sformatf("tv%0d_code", i), 32'(dut_code()), 32'(tv[i].c_on));
      chk($sformatf("tv%0d_fwdA", i), 32'(hif.fwdA_E), 32'(tv[i].fa));
      chk($sformatf("tv%0d_fwdB", i), 32'(hif.fwdB_E), 32'(tv[i].fb));
`else
      chk($sformatf("tv%0d_code", i), 32'(dut_code()), 32'(tv[i].c_off));
      chk($sformatf("tv%0d_fwdA", i), 32'(hif.fwdA_E), 32'd0);
      chk($sformatf("tv%0d_fwdB", i), 32'(hif.fwdB_E), 32'd0);
`endif
      @(posedge CLK); #1;
    end

    // Load-use: one bubble, one counted stall cycle
    do_reset();
    v = z; v.ldE = 1; v.weE = 1; v.rdE = 5'd5; v.rs1D = 5'd5;
    apply(v);
    @(negedge CLK);
    chk("lu_code", 32'(dut_code()), 32'(C_LU));
    @(posedge CLK); #1;
    apply(z);
    @(negedge CLK);
    chk("lu_after", 32'(dut_code()), 32'(C_NONE));
    chk("lu_sc", hif.stall_cycles, 32'd1);

    // Memory wait of 3 cycles
    do_reset();
    v = z; v.req = 1;
    apply(v);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("mw_stall%0d", k), 32'(dut_code()), 32'(C_MEM));
      @(posedge CLK); #1;
    end
    v.rdy = 1;
    apply(v);
    @(negedge CLK);
    chk("mw_ready", 32'(dut_code()), 32'(C_NONE));
    @(posedge CLK); #1;
    apply(z);
    @(negedge CLK);
    chk("mw_run", 32'(dut_code()), 32'(C_NONE));
    chk("mw_sc", hif.stall_cycles, 32'd3);

    // Timeout to ERR, then async reset out of it
    do_reset();
    v = z; v.req = 1;
    apply(v);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk($sformatf("to_err%0d", k), 32'(hif.mem_err), 32'd0);
      @(posedge CLK); #1;
    end
    apply(z);
    @(negedge CLK);
    chk("to_err", 32'(hif.mem_err), 32'd1);
    chk("to_code", 32'(dut_code()), 32'(C_MEM));
    chk("to_sc", hif.stall_cycles, 32'd5);
    #2 RST = 1'b1;
    #1;
    chk("to_rst_err", 32'(hif.mem_err), 32'd0);
    chk("to_rst_code", 32'(dut_code()), 32'(C_RST));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("to_run", 32'(dut_code()), 32'(C_NONE));
    @(posedge CLK); #1;

    // Random traffic against the model
    m_pend = 0; m_err = 1'b0; m_sc = 0;
    for (int i = 0; i < 3000; i++) begin
      v.rs1D = 5'($urandom_range(0, 7)); v.rs2D = 5'($urandom_range(0, 7));
      v.rs1E = 5'($urandom_range(0, 7)); v.rs2E = 5'($urandom_range(0, 7));
      v.rdE  = 5'($urandom_range(0, 7)); v.rdM  = 5'($urandom_range(0, 7));
      v.rdW  = 5'($urandom_range(0, 7));
      v.weE = 1'($urandom); v.weM = 1'($urandom); v.weW = 1'($urandom);
      v.ldE = 1'($urandom); v.pc = ($urandom_range(0, 5) == 0);
      v.req = ($urandom_range(0, 3) == 0); v.rdy = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 99) == 0);
      RST = r;
      apply(v);
      if (r) begin m_pend = 0; m_err = 1'b0; m_sc = 0; end
      @(negedge CLK);
      ec = m_code(v, r);
      chk("rnd_code", 32'(dut_code()), 32'(ec));
      chk("rnd_fwdA", 32'(hif.fwdA_E), 32'(m_fwd(v, v.rs1E)));
      chk("rnd_fwdB", 32'(hif.fwdB_E), 32'(m_fwd(v, v.rs2E)));
      chk("rnd_err", 32'(hif.mem_err), 32'(m_err));
      chk("rnd_sc", hif.stall_cycles, 32'(m_sc));
      @(posedge CLK);
      if (!r) begin
        if (ec[6] && m_sc < 64'hFFFF_FFFF) m_sc++;
        if (!m_err) begin
          m_pend = ec[3] ? m_pend + 1 : 0;
          if (m_pend >= TMO + 1) m_err = 1'b1;
        end
      end
      #1;
    end
    RST = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the five-stage OTTER pipeline. It drives the flush and stall inputs of every inter-stage register, including flush_E of the decode/execute register. It also supplies forwarding selects to the execute-stage ALU muxes and sequences multi-cycle data-memory waits through a small FSM with a timeout. It sits beside the datapath, fed by register addresses and control bits from the D, E, M and W stages.

## Interface
- MEM_TIMEOUT, 64: maximum cycles spent in MEM_WAIT before the controller declares a memory error.
- CLK  in  1  pipeline clock
- RST  in  1  asynchronous, active-high reset
- rs1_addr_D, rs2_addr_D  in  5 each  source register fields of the decode-stage instruction
- rs1_addr_E, rs2_addr_E  in  5 each  source register fields of the execute-stage instruction
- rd_E, rd_M, rd_W  in  5 each  destination fields of the E, M and W stages
- regWrite_E, regWrite_M, regWrite_W  in  1 each  register-write enables of those stages
- memRead2_E  in  1  the execute-stage instruction is a load
- pc_src_E  in  1  a branch or jump resolved taken in execute
- mem_req_M  in  1  a load or store is in the memory stage
- mem_ready  in  1  data-memory acknowledge for the current request
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold the PC, IF/D, D/E and E/M registers
- flush_D, flush_E, flush_W  out  1 each  insert a bubble into the IF/D, D/E and M/W registers
- fwdA_E, fwdB_E  out  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M result
- mem_err  out  1  sticky memory-timeout flag
- stall_cycles  out  32  saturating count of cycles with stall_F=1

## Operation
- FSM states:
  - RUN: reset state.
  - MEM_WAIT
  - ERR
- RUN → MEM_WAIT when mem_req_M=1 and mem_ready=0.
- MEM_WAIT → RUN on mem_ready=1.
- MEM_WAIT → ERR when wait_cnt reaches MEM_TIMEOUT-1 with mem_ready=0.
- ERR is left only by RST.
- Memory stall condition: (RUN & mem_req_M & !mem_ready) | (MEM_WAIT & !mem_ready) | ERR.
  - Effect: stall_F, stall_D, stall_E and stall_M all 1, flush_W=1.
  - All other flushes are suppressed; a memory stall overrides both the branch and the load-use rules.
- Branch rule, when there is no memory stall: pc_src_E=1 → flush_D=1 and flush_E=1, with no stalls.
- Load-use rule, when there is no memory stall and no branch:
  - Fires when memRead2_E & regWrite_E & rd_E≠0 & (rd_E==rs1_addr_D | rd_E==rs2_addr_D).
  - Effect: stall_F=1, stall_D=1, flush_E=1.
- Forwarding, per operand A (rs1_addr_E) and B (rs2_addr_E):
  - 10 if regWrite_M & rd_M≠0 & rd_M==rs.
  - Otherwise 01 if regWrite_W & rd_W≠0 & rd_W==rs.
  - Otherwise 00.
  - M has priority over W.
- wait_cnt is 7 bits or wider ($clog2(MEM_TIMEOUT)+1). It clears on entry to MEM_WAIT and increments each cycle spent in MEM_WAIT.
- mem_err=1 exactly while the state is ERR.
- stall_cycles increments when stall_F=1 and holds at 32'hFFFF_FFFF.

## Timing
- All stall, flush and forward outputs are combinational from the current state and inputs, so they take effect in the same cycle.
- State, wait_cnt and stall_cycles update on posedge CLK.
- Load-use costs exactly one bubble; a taken branch costs two squashed instructions.
- Memory wait of N cycles (mem_ready arrives N cycles after mem_req_M) costs N stall cycles. The cycle in which mem_ready=1 is not stalled.
- Reset values:
  - State RUN, wait_cnt 0, stall_cycles 0, mem_err 0.
  - While RST=1, flush_D=flush_E=flush_W=1 and all stalls are 0.
- RST asserted mid-MEM_WAIT or in ERR returns to RUN asynchronously.
- mem_ready=1 while in RUN with mem_req_M=0 is ignored.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding as described above.
- HAZARD_FORWARDING_EN undefined:
  - fwdA_E and fwdB_E are tied to 00.
  - Any RAW hazard of rs1_addr_D or rs2_addr_D against E, or against M (with regWrite and rd≠0), gives stall_F=stall_D=flush_E=1.
  - W needs no stall because the register file is write-first.

## Structure
- The hazard_pkg package holds:
  - the state enum typedef (RUN, MEM_WAIT, ERR)
  - the forward-select constants FWD_RF, FWD_W, FWD_M
  - the 5-bit register-address typedef
- One sub-module, hazard_fwd_sel: a combinational comparator instantiated once per operand.

## Test plan
- Load-use: lw x5 in E (memRead2_E=1, rd_E=5), D reads rs1=5 → stall_F=stall_D=flush_E=1 for one cycle; stall_cycles=1.
- Forward priority: rd_M=rd_W=7, both writing, rs2_addr_E=7 → fwdB_E=10; with rd_M=0 → fwdB_E=01.
- Branch plus load-use in the same cycle: pc_src_E=1 → flush_D=flush_E=1, stall_F=0.
- Memory wait: mem_req_M=1, mem_ready low for 3 cycles → stall_M and flush_W high for 3 cycles, FSM returns to RUN after ready; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_ready never asserted → ERR after 5 stall cycles, mem_err=1; asynchronous RST clears to RUN with mem_err=0.
- Macro off: add x3 in E writing x3, D reads x3 → stall plus flush_E, fwdA_E=00.
